// File: rtl/multi_irq_controller_pkg.sv
// multi_irq_controller_pkg: shared core types and constants for the interrupt controller.
package multi_irq_controller_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXC,
        IRQ,
        IRQ_EXC
    } irq_state_e;

    localparam logic [31:0] MCAUSE_IRQ_BIT    = 32'h8000_0000;
    localparam logic [31:0] EXC_CAUSE_ILLEGAL = 32'd2;

endpackage

// File: rtl/multi_irq_controller_prio_enc_n.sv
// prio_enc_n: lowest-set-index priority encoder.
module prio_enc_n #(
    parameter int N = 16,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = W'(i);
        end
    end

endmodule

// File: rtl/multi_irq_controller.sv
// multi_irq_controller: fixed-priority interrupt arbitration with exception and mret tracking.
module multi_irq_controller
    import multi_irq_controller_pkg::*;
#(
    parameter int               N_IRQ      = 16,
    parameter int               CAUSE_BASE = 16,
    parameter logic [N_IRQ-1:0] EDGE_MASK  = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             exception_i,
    input  logic [N_IRQ-1:0] irq_req_i,
    input  logic [N_IRQ-1:0] mie_i,
    input  logic             mret_i,
    input  logic             stall_i,
    output logic             irq_o,
    output logic [31:0]      irq_cause_o,
    output logic             irq_ret_o,
    output logic [N_IRQ-1:0] irq_ack_o
);

    localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    irq_state_e       state_q, state_d;
    logic [N_IRQ-1:0] pend_q, pend_d, prev_q, pending, eligible, clr;
    logic [IW-1:0]    idx_q, win;
    logic [31:0]      cause_q, cause_now;
    logic             valid, take;

    // Edge channels use the latched bit, level channels follow the request directly.
    assign pending  = (pend_q & EDGE_MASK) | (irq_req_i & ~EDGE_MASK);
    assign eligible = pending & mie_i;

    prio_enc_n #(.N(N_IRQ), .W(IW)) u_prio (
        .req_i  (eligible),
        .valid_o(valid),
        .idx_o  (win)
    );

    assign take      = rst_i && state_q == IDLE && valid && !exception_i && !stall_i;
    assign cause_now = MCAUSE_IRQ_BIT | {1'b0, 31'(CAUSE_BASE + int'(win))};
    assign clr       = take ? (EDGE_MASK & (N_IRQ'(1) << win)) : '0;
    // A fresh rising edge outranks the clear of the channel being taken.
    assign pend_d    = ((pend_q & ~clr) | (irq_req_i & ~prev_q)) & EDGE_MASK;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = exception_i ? EXC : take ? IRQ : IDLE;
            EXC:     state_d = (!exception_i && mret_i) ? IDLE : EXC;
            IRQ:     state_d = exception_i ? IRQ_EXC : mret_i ? IDLE : IRQ;
            IRQ_EXC: state_d = (!exception_i && mret_i) ? IRQ : IRQ_EXC;
            default: state_d = IDLE;
        endcase
    end

    assign irq_o       = take;
    assign irq_ret_o   = state_q == IRQ && mret_i && !exception_i;
    assign irq_ack_o   = irq_ret_o ? (N_IRQ'(1) << idx_q) : '0;
    assign irq_cause_o = take ? cause_now
                       : (state_q == IRQ || state_q == IRQ_EXC) ? cause_q : '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            pend_q  <= '0;
            prev_q  <= '0;
            idx_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            prev_q  <= irq_req_i;
            if (take) begin
                idx_q   <= win;
                cause_q <= cause_now;
            end
        end
    end

endmodule

// File: tb/tb_multi_irq_controller.sv
// tb_multi_irq_controller: directed and random stimulus against a handler-level reference model.
module tb_multi_irq_controller;

    localparam logic [15:0] EM = 16'h00FF;

    logic        clk_i = 0, rst_i = 1, exception_i = 0, mret_i = 0, stall_i = 0;
    logic [15:0] irq_req_i = '0, mie_i = '0;
    logic        irq_o, irq_ret_o;
    logic [31:0] irq_cause_o;
    logic [15:0] irq_ack_o;

    multi_irq_controller #(.N_IRQ(16), .CAUSE_BASE(16), .EDGE_MASK(EM)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .exception_i(exception_i),
        .irq_req_i  (irq_req_i),
        .mie_i      (mie_i),
        .mret_i     (mret_i),
        .stall_i    (stall_i),
        .irq_o      (irq_o),
        .irq_cause_o(irq_cause_o),
        .irq_ret_o  (irq_ret_o),
        .irq_ack_o  (irq_ack_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, errors = 0;

    bit [15:0]   m_pend, m_prev;
    bit          in_irq, in_exc;
    int          act;
    logic [31:0] act_cause;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_prev = '0; in_irq = 0; in_exc = 0; act = 0; act_cause = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_irq"}, 32'(irq_o), 0);
        check({tag, "_cause"}, irq_cause_o, 0);
        check({tag, "_ret"}, 32'(irq_ret_o), 0);
        check({tag, "_ack"}, 32'(irq_ack_o), 0);
    endtask

    // Called at a falling edge with inputs already driven; checks, then advances one clock.
    task automatic cycle();
        logic [15:0] pend, elig, e_ack;
        logic [31:0] e_cause;
        bit          e_irq, e_ret;
        int          win;
        #1;
        pend = (m_pend & EM) | (irq_req_i & ~EM);
        elig = pend & mie_i;
        win  = -1;
        for (int i = 0; i < 16; i++) if (elig[i] && win < 0) win = i;
        e_irq   = !in_irq && !in_exc && win >= 0 && !exception_i && !stall_i;
        e_cause = e_irq ? 32'h8000_0000 + 32'(16 + win) : (in_irq ? act_cause : 32'h0);
        e_ret   = in_irq && !in_exc && mret_i && !exception_i;
        e_ack   = e_ret ? 16'(1) << act : 16'h0;
        check("irq_o", 32'(irq_o), 32'(e_irq));
        check("irq_cause_o", irq_cause_o, e_cause);
        check("irq_ret_o", 32'(irq_ret_o), 32'(e_ret));
        check("irq_ack_o", 32'(irq_ack_o), 32'(e_ack));
        @(posedge clk_i);
        for (int i = 0; i < 16; i++) begin
            if (EM[i] && irq_req_i[i] && !m_prev[i]) m_pend[i] = 1;
            else if (e_irq && win == i) m_pend[i] = 0;
        end
        m_prev = irq_req_i;
        if (exception_i) in_exc = 1;
        else if (mret_i && in_exc) in_exc = 0;
        else if (mret_i && in_irq) in_irq = 0;
        else if (e_irq) begin
            in_irq = 1; act = win; act_cause = e_cause;
        end
        @(negedge clk_i);
    endtask

    task automatic drive(input logic [15:0] req, input bit exc, input bit mret, input bit stall);
        irq_req_i = req; exception_i = exc; mret_i = mret; stall_i = stall;
        cycle();
    endtask

    initial begin
        #1 rst_i = 0;
        irq_req_i = 16'h0100; mie_i = 16'hFFFF;
        #22 check_zero("reset");
        irq_req_i = '0;
        @(negedge clk_i);
        rst_i = 1;
        model_reset();

        mie_i = 16'h0008;
        drive(16'h0008, 0, 0, 0);
        drive(16'h0000, 0, 0, 0);
        check("pulse3_cause", irq_cause_o, 32'h8000_0013);
        drive(16'h0000, 0, 0, 0);
        drive(16'h0000, 0, 1, 0);

        mie_i = 16'h0024;
        drive(16'h0024, 0, 0, 0);
        drive(16'h0000, 0, 0, 0);
        drive(16'h0000, 0, 1, 0);
        drive(16'h0000, 0, 0, 0);
        drive(16'h0000, 0, 1, 0);

        mie_i = 16'h0008;
        drive(16'h0008, 0, 0, 0);
        drive(16'h0000, 0, 0, 0);
        drive(16'h0000, 1, 0, 0);
        drive(16'h0000, 0, 1, 0);
        drive(16'h0000, 0, 1, 0);

        mie_i = 16'h0100;
        drive(16'h0100, 1, 0, 0);
        drive(16'h0100, 0, 1, 0);
        drive(16'h0100, 0, 0, 0);
        drive(16'h0000, 0, 0, 0);
        drive(16'h0000, 0, 1, 0);

        drive(16'h0100, 0, 0, 1);
        drive(16'h0100, 0, 0, 1);
        drive(16'h0100, 0, 0, 0);
        drive(16'h0000, 0, 1, 0);

        mie_i = 16'h0018;
        drive(16'h0008, 0, 0, 0);
        drive(16'h0000, 0, 0, 0);
        drive(16'h0010, 0, 0, 0);
        drive(16'h0000, 0, 0, 0);
        check("irq_active_cause", irq_cause_o, 32'h8000_0013);
        rst_i = 0;
        #1 check_zero("async_reset");
        model_reset();
        irq_req_i = '0; mret_i = 0;
        @(negedge clk_i);
        rst_i = 1;
        drive(16'h0000, 0, 0, 0);
        drive(16'h0000, 0, 0, 0);

        for (int n = 0; n < 2000; n++) begin
            bit e, m;
            e = ($urandom_range(7) == 0);
            m = !e && ($urandom_range(3) == 0);
            mie_i = 16'($urandom);
            drive(16'($urandom) & 16'($urandom), e, m, $urandom_range(5) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
